// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Request/response bundle between the two front-end requesters and the
//   ALU arbiter.
//   master : requester side (drives reqN_valid/op/a/b, observes ready and responses)
//   slave  : arbiter side   (drives reqN_ready, rspN_valid, rsp_y, rsp_flags)
//   W      : operand/result width (4, matches the shared ALU)
interface alu_arbiter_if #(
   parameter int W = 4
);
   logic          req0_valid;
   logic          req0_ready;
   logic [2:0]    req0_op;
   logic [W-1:0]  req0_a;
   logic [W-1:0]  req0_b;

   logic          req1_valid;
   logic          req1_ready;
   logic [2:0]    req1_op;
   logic [W-1:0]  req1_a;
   logic [W-1:0]  req1_b;

   logic          rsp0_valid;
   logic          rsp1_valid;
   logic [W-1:0]  rsp_y;
   logic [3:0]    rsp_flags;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp1_valid, rsp_y, rsp_flags
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp1_valid, rsp_y, rsp_flags
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester arbiter and sequencer for the shared combinational 4-bit ALU.
//   Accepts one operation at a time, drives registered operands/opcode to the
//   ALU, waits ALU_LAT cycles, captures Y and {N,Z,C,V}, and returns them to the
//   granted requester with a one-cycle response pulse.
//
//   Ports
//     clk, rst_n              clock (rising edge), async active-low reset
//     bus (alu_arbiter_if)    request handshakes and response pulses/data
//     busy                    high whenever the FSM is not idle
//     alu_a/alu_b/alu_op      registered operands and opcode to the ALU
//     alu_y/alu_n/z/c/v       ALU result and flags
//
//   Parameters
//     W        operand width, fixed at 4
//     ALU_LAT  cycles the operands are held before capture, 1..7
//
//   Build option
//     ALU_ARB_FIXED_PRIO_EN   when defined, requester 0 always wins a tie;
//                             otherwise ties are resolved round-robin.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a request; ready offered to the winner
//   EXEC  | operands held on the ALU for ALU_LAT cycles, capture on last
//   RESP  | one-cycle response pulse to the granted requester
module alu_arbiter #(
   parameter int W       = 4,
   parameter int ALU_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  bus,
   output logic          busy,
   output logic [W-1:0]  alu_a,
   output logic [W-1:0]  alu_b,
   output logic [2:0]    alu_op,
   input  logic [W-1:0]  alu_y,
   input  logic          alu_n,
   input  logic          alu_z,
   input  logic          alu_c,
   input  logic          alu_v
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [2:0] CNT_LAST = 3'(ALU_LAT - 1);

   state_t        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          gid_q, gid_d;
   logic [W-1:0]  alu_a_q, alu_a_d;
   logic [W-1:0]  alu_b_q, alu_b_d;
   logic [2:0]    alu_op_q, alu_op_d;
   logic [W-1:0]  rsp_y_q, rsp_y_d;
   logic [3:0]    rsp_flags_q, rsp_flags_d;
   logic          gnt0, gnt1;
`ifndef ALU_ARB_FIXED_PRIO_EN
   logic          last_q, last_d;
`endif

   // Grant decision, only meaningful in IDLE.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == S_IDLE) begin
         if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            gnt0 = 1'b1;
`else
            // last_q holds the id of the previous winner; the other one wins now
            gnt0 = last_q;
            gnt1 = ~last_q;
`endif
         end else begin
            gnt0 = bus.req0_valid;
            gnt1 = bus.req1_valid;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      gid_d       = gid_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      rsp_y_d     = rsp_y_q;
      rsp_flags_d = rsp_flags_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_d      = last_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (gnt0 || gnt1) begin
               if (gnt1) begin
                  alu_a_d  = bus.req1_a;
                  alu_b_d  = bus.req1_b;
                  alu_op_d = bus.req1_op;
               end else begin
                  alu_a_d  = bus.req0_a;
                  alu_b_d  = bus.req0_b;
                  alu_op_d = bus.req0_op;
               end
               gid_d   = gnt1;
`ifndef ALU_ARB_FIXED_PRIO_EN
               last_d  = gnt1;
`endif
               cnt_d   = 3'd0;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (cnt_q == CNT_LAST) begin
               rsp_y_d     = alu_y;
               rsp_flags_d = {alu_n, alu_z, alu_c, alu_v};
               cnt_d       = 3'd0;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 3'd0;
         gid_q       <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= 3'd0;
         rsp_y_q     <= '0;
         rsp_flags_q <= 4'd0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last_q      <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gid_q       <= gid_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         rsp_y_q     <= rsp_y_d;
         rsp_flags_q <= rsp_flags_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last_q      <= last_d;
`endif
      end
   end

   // ready is combinational from valid, so it is masked by rst_n to keep every
   // output low while reset is held.
   assign bus.req0_ready = rst_n & gnt0;
   assign bus.req1_ready = rst_n & gnt1;
   assign bus.rsp0_valid = (state_q == S_RESP) & ~gid_q;
   assign bus.rsp1_valid = (state_q == S_RESP) &  gid_q;
   assign bus.rsp_y      = rsp_y_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign busy           = (state_q != S_IDLE);
   assign alu_a          = alu_a_q;
   assign alu_b          = alu_b_q;
   assign alu_op         = alu_op_q;

endmodule
